// File: rtl/usb_rx_crc16_strip.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | usb_rx_crc16_strip: checks CRC-16/USB on received data packets and strips   |
// | the two trailing CRC bytes through a 2-byte holding pipeline.               |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module usb_rx_crc16_strip #(
  parameter int MAX_LEN = 1023,
  parameter int LEN_W   = 11,
  parameter bit CRC_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_sop,
  input  logic             rx_eop,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  input  logic             rx_cancel,
  output logic             out_sop,
  output logic             out_eop,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             pkt_done,
  output logic             crc16_err,
  output logic             len_err,
  output logic [LEN_W-1:0] pkt_len
);

  localparam logic [15:0]      c_CRC_INIT = 16'hFFFF;
  localparam logic [15:0]      c_CRC_POLY = 16'hA001;
  localparam logic [LEN_W-1:0] c_LEN_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [7:0]       h0_q, h0_d;
  logic [7:0]       h1_q, h1_d;
  logic [15:0]      crc_q, crc_d;
  logic             first_q, first_d;
  logic             out_valid_q, out_valid_d;
  logic             out_sop_q, out_sop_d;
  logic             out_eop_q, out_eop_d;
  logic [7:0]       out_data_q, out_data_d;
  logic [LEN_W-1:0] pkt_len_q, pkt_len_d;
  logic             crc_err_q, crc_err_d;
  logic             len_err_q, len_err_d;

  logic             w_accept;
  logic [15:0]      w_crc_h0;
  logic [LEN_W-1:0] w_len_inc;
  logic [15:0]      w_fin_crc;
  logic [15:0]      w_fin_bytes;
  logic [LEN_W-1:0] w_fin_len;
  logic             w_crc_mis;
  logic             w_len_over;

  // Reflected CRC-16 update for one byte, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ c_CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  assign rx_ready  = (state_q != ST_DONE) && (!out_valid_q || out_ready);
  assign w_accept  = rx_valid && rx_ready;
  assign w_crc_h0  = crc16_byte(crc_q, h0_q);
  assign w_len_inc = (pkt_len_q == c_LEN_MAX) ? pkt_len_q : pkt_len_q + 1'b1;

  // With two bytes held, h0 is the last payload byte and h1 the CRC low byte.
  assign w_fin_crc   = (cnt_q == 2'd2) ? w_crc_h0 : crc_q;
  assign w_fin_bytes = (cnt_q == 2'd2) ? {rx_data, h1_q} : {rx_data, h0_q};
  assign w_fin_len   = (cnt_q == 2'd2) ? w_len_inc : pkt_len_q;
  assign w_len_over  = {{(32-LEN_W){1'b0}}, w_fin_len} > 32'(MAX_LEN);

  generate
    if (CRC_EN) begin : g_crc_on
      assign w_crc_mis = (~w_fin_crc != w_fin_bytes);
    end else begin : g_crc_off
      assign w_crc_mis = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    h0_d        = h0_q;
    h1_d        = h1_q;
    crc_d       = crc_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_data_d  = out_data_q;
    pkt_len_d   = pkt_len_q;
    crc_err_d   = crc_err_q;
    len_err_d   = len_err_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
    end

    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (w_accept && rx_sop) begin
          // A sop always restarts, discarding whatever a running packet held.
          state_d   = rx_eop ? ST_DONE : ST_RUN;
          h0_d      = rx_data;
          cnt_d     = rx_eop ? 2'd0 : 2'd1;
          crc_d     = c_CRC_INIT;
          first_d   = 1'b1;
          pkt_len_d = '0;
          crc_err_d = 1'b0;
          len_err_d = rx_eop;
        end else if (state_q == ST_RUN && rx_cancel) begin
          state_d = ST_IDLE;
          cnt_d   = 2'd0;
          crc_d   = c_CRC_INIT;
        end else if (state_q == ST_RUN && w_accept) begin
          if (cnt_q == 2'd2) begin
            out_valid_d = 1'b1;
            out_data_d  = h0_q;
            out_sop_d   = first_q;
            out_eop_d   = rx_eop;
            first_d     = 1'b0;
            crc_d       = w_crc_h0;
            pkt_len_d   = w_len_inc;
            h0_d        = h1_q;
            h1_d        = rx_data;
          end else if (cnt_q == 2'd1) begin
            h1_d  = rx_data;
            cnt_d = 2'd2;
          end else begin
            h0_d  = rx_data;
            cnt_d = 2'd1;
          end
          if (rx_eop) begin
            state_d   = ST_DONE;
            cnt_d     = 2'd0;
            crc_err_d = w_crc_mis;
            len_err_d = w_len_over;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        crc_d   = c_CRC_INIT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      h0_q        <= 8'h00;
      h1_q        <= 8'h00;
      crc_q       <= c_CRC_INIT;
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_data_q  <= 8'h00;
      pkt_len_q   <= '0;
      crc_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      h0_q        <= h0_d;
      h1_q        <= h1_d;
      crc_q       <= crc_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_data_q  <= out_data_d;
      pkt_len_q   <= pkt_len_d;
      crc_err_q   <= crc_err_d;
      len_err_q   <= len_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_data  = out_data_q;
  assign pkt_done  = (state_q == ST_DONE);
  assign crc16_err = crc_err_q;
  assign len_err   = len_err_q;
  assign pkt_len   = pkt_len_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_crc16_strip.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_usb_rx_crc16_strip: randomized scoreboard bench for usb_rx_crc16_strip,  |
// | driving a default instance and a MAX_LEN=4 instance in lockstep.            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_usb_rx_crc16_strip;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {logic [7:0] d; logic s; logic e;} beat_t;
  typedef struct packed {logic [10:0] len; logic crc; logic lerr;} st_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_sop, rx_eop, rx_valid, rx_cancel, out_ready;
  logic [7:0]  rx_data;
  logic        rx_ready, out_sop, out_eop, out_valid, pkt_done, crc16_err, len_err;
  logic [7:0]  out_data;
  logic [10:0] pkt_len;
  logic        rx_ready_s, out_sop_s, out_eop_s, out_valid_s, pkt_done_s, crc16_err_s, len_err_s;
  logic [7:0]  out_data_s;
  logic [2:0]  pkt_len_s;

  int n_tests = 0;
  int n_fail  = 0;
  int bp_mode = 0;
  beat_t exp_b[$], exp_bs[$];
  st_t   exp_s[$], exp_ss[$];
  beat_t mb;
  st_t   ms;

  always #5 clk = ~clk;

  usb_rx_crc16_strip #(.MAX_LEN(1023), .LEN_W(11), .CRC_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_cancel(rx_cancel), .out_sop(out_sop),
    .out_eop(out_eop), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .pkt_done(pkt_done), .crc16_err(crc16_err), .len_err(len_err), .pkt_len(pkt_len));

  usb_rx_crc16_strip #(.MAX_LEN(4), .LEN_W(3), .CRC_EN(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready_s), .rx_cancel(rx_cancel), .out_sop(out_sop_s),
    .out_eop(out_eop_s), .out_valid(out_valid_s), .out_data(out_data_s), .out_ready(out_ready),
    .pkt_done(pkt_done_s), .crc16_err(crc16_err_s), .len_err(len_err_s), .pkt_len(pkt_len_s));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bit-serial CRC-16/USB straight from the polynomial definition; returns ~reg.
  function automatic logic [15:0] model_crc(input bq_t p);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (p[i]) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ p[i][j];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return ~c;
  endfunction

  // Scoreboard monitor: compare whatever the DUTs present against queued expectations.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !out_ready) chk("rx_ready_bp", 32'(rx_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_b.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL beat: got unexpected byte %0h, required none", out_data);
        end else begin
          mb = exp_b.pop_front();
          chk("beat", 32'({out_data, out_sop, out_eop}), 32'(mb));
        end
      end
      if (pkt_done) begin
        if (exp_s.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL status: got unexpected pkt_done, required none");
        end else begin
          ms = exp_s.pop_front();
          chk("status", 32'({pkt_len, crc16_err, len_err}), 32'(ms));
        end
      end
      if (out_valid_s && out_ready) begin
        if (exp_bs.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL beat_small: got unexpected byte %0h, required none", out_data_s);
        end else begin
          mb = exp_bs.pop_front();
          chk("beat_small", 32'({out_data_s, out_sop_s, out_eop_s}), 32'(mb));
        end
      end
      if (pkt_done_s) begin
        if (exp_ss.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL status_small: got unexpected pkt_done, required none");
        end else begin
          ms = exp_ss.pop_front();
          chk("status_small", 32'({8'd0, pkt_len_s, crc16_err_s, len_err_s}), 32'(ms));
        end
      end
    end
  end

  // Backpressure generator: 0 = always ready, 1 = 50%, 2 = ready one cycle in three.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        1:       out_ready = ($urandom_range(0, 1) == 0);
        2:       out_ready = ($urandom_range(0, 2) == 0);
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic drive_byte(input logic [7:0] d, input logic s, input logic e);
    int   t;
    logic ok;
    rx_valid = 1'b1; rx_data = d; rx_sop = s; rx_eop = e;
    t = 0; ok = 1'b0;
    while (!ok && t < 500) begin
      @(negedge clk);
      ok = rx_ready;
      t++;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: rx_ready got 0, required 1");
    end
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
  endtask

  // cut>0: only the first cut bytes are sent, then the packet is aborted by a
  // cancel pulse (use_cancel) or by the next packet's sop.
  task automatic send_pkt(input bq_t b, input int cut, input bit use_cancel);
    int   n, pl, m;
    bq_t  p;
    st_t  st;
    n  = b.size();
    pl = (n >= 2) ? n - 2 : 0;
    m  = (cut > 0) ? cut : n;
    if (cut > 0) begin
      for (int i = 0; i < cut - 2; i++) begin
        exp_b.push_back({b[i], (i == 0), 1'b0});
        exp_bs.push_back({b[i], (i == 0), 1'b0});
      end
    end else begin
      for (int i = 0; i < pl; i++) begin
        p.push_back(b[i]);
        exp_b.push_back({b[i], (i == 0), (i == pl - 1)});
        exp_bs.push_back({b[i], (i == 0), (i == pl - 1)});
      end
      st.len  = 11'(pl);
      st.crc  = (n >= 2) && (model_crc(p) != {b[n-1], b[n-2]});
      st.lerr = (n < 2) || (pl > 1023);
      exp_s.push_back(st);
      st.len  = (pl > 7) ? 11'd7 : 11'(pl);
      st.lerr = (n < 2) || (pl > 4);
      exp_ss.push_back(st);
    end
    for (int i = 0; i < m; i++) drive_byte(b[i], (i == 0), (cut == 0) && (i == n - 1));
    if (cut > 0 && use_cancel) begin
      rx_cancel = 1'b1;
      @(posedge clk); #1;
      rx_cancel = 1'b0;
    end
  endtask

  function automatic bq_t make_pkt(input int pl, input bit good);
    bq_t         b;
    logic [15:0] c;
    for (int i = 0; i < pl; i++) b.push_back(8'($urandom_range(0, 255)));
    c = model_crc(b);
    b.push_back(c[7:0]);
    b.push_back(c[15:8]);
    if (!good) b[pl+1] = b[pl+1] ^ (8'h01 << $urandom_range(0, 7));
    return b;
  endfunction

  initial begin
    bq_t b;
    bit  restart;
    int  r, n, t;
    rst = 1'b1; rx_sop = 1'b0; rx_eop = 1'b0; rx_valid = 1'b0; rx_cancel = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out", 32'({out_valid, out_sop, out_eop, out_data, pkt_done}), 32'd0);
    chk("reset_status", 32'({crc16_err, len_err, pkt_len}), 32'd0);
    chk("reset_rx_ready", 32'(rx_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    b = '{8'h00, 8'h00};
    send_pkt(b, 0, 1'b0);
    b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
    send_pkt(b, 0, 1'b0);
    b[10] = 8'hB5;
    send_pkt(b, 0, 1'b0);
    bp_mode = 2;
    b[10] = 8'hB4;
    send_pkt(b, 0, 1'b0);
    send_pkt(b, 4, 1'b1);
    bp_mode = 0;
    b = '{8'h00, 8'h00};
    send_pkt(b, 0, 1'b0);
    b = make_pkt(5, 1'b1);
    send_pkt(b, 0, 1'b0);
    b = '{8'hA5};
    send_pkt(b, 0, 1'b0);

    restart = 1'b0;
    for (int k = 0; k < 60; k++) begin
      bp_mode = $urandom_range(0, 2);
      if (!restart) begin
        repeat ($urandom_range(0, 2)) drive_byte(8'($urandom_range(0, 255)), 1'b0, 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 9) == 0) begin
        b = '{8'($urandom_range(0, 255))};
      end else begin
        b = make_pkt($urandom_range(0, 20), ($urandom_range(0, 3) != 0));
      end
      n = b.size();
      r = (k == 59 || n < 2) ? 9 : $urandom_range(0, 6);
      restart = (r == 1);
      if (r <= 1) send_pkt(b, $urandom_range(1, n - 1), (r == 0));
      else send_pkt(b, 0, 1'b0);
      if (!restart) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    bp_mode = 0;
    t = 0;
    while ((exp_b.size() + exp_bs.size() + exp_s.size() + exp_ss.size()) != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_beats", 32'(exp_b.size() + exp_bs.size()), 32'd0);
    chk("drain_status", 32'(exp_s.size() + exp_ss.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
